// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO fed over valid/ready, drained LSB-first onto uart_tx
// with no idle gap between consecutive frames.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic push, pop, baud_wrap, fifo_nonempty;

  assign baud_wrap     = (baud_q == CntW'(BAUD_DIV - 1));
  assign fifo_nonempty = (count_q != '0);
  // Acceptance depends on the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready      = (count_q != CountW'(FIFO_DEPTH));
  assign push          = in_valid && in_ready;

  assign uart_tx    = tx_q;
  assign tx_busy    = (state_q != StIdle);
  assign tx_done    = (state_q == StStop) && baud_wrap;
  assign fifo_count = count_q;

  // Frame sequencing: next state, baud counter, shift register and serial line level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit: zero idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; the line returns high immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: each accepted byte is queued with its predicted start cycle;
// a line monitor checks every frame cycle, and a timeline model predicts fifo_count/in_ready.
module tb_uart_tx_fifo;

  localparam int BaudDiv  = 4;
  localparam int Depth    = 4;
  localparam int FrameLen = 10 * BaudDiv;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, uart_tx, tx_busy, tx_done;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .BAUD_DIV  (BaudDiv),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         acc;    // edge at which the byte was accepted
    int         start;  // edge at which its start bit must fall
    logic [7:0] data;
  } ent_t;

  ent_t pend[$];
  int   last_start = -1000000;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   peak_cnt = 0;
  bit   mon_active = 1'b0;
  int   mon_pos = 0;
  ent_t cur;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endfunction

  // Bytes queued = accepted so far but whose start edge has not yet been reached.
  function automatic int exp_count(input int e);
    int c = 0;
    foreach (pend[i]) if (pend[i].acc <= e && pend[i].start > e) c++;
    return c;
  endfunction

  // A frame starts one edge after acceptance, but never sooner than one frame after the last.
  function automatic void add_entry(input logic [7:0] b);
    int acc = cyc + 1;
    int s   = acc + 1;
    if (last_start + FrameLen > s) s = last_start + FrameLen;
    last_start = s;
    pend.push_back('{acc, s, b});
  endfunction

  // Occupancy model check plus serial line monitor, sampled on the falling edge.
  initial forever begin
    int c;
    int expl;
    @(negedge clk);
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      c = exp_count(cyc);
      chk("fifo_count", int'(fifo_count), c);
      chk("in_ready", int'(in_ready), (c != Depth) ? 1 : 0);
      if (int'(fifo_count) > peak_cnt) peak_cnt = int'(fifo_count);
      if (!mon_active) begin
        if (uart_tx === 1'b0) begin
          if (pend.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame at cycle %0d: got start bit, expected idle line", cyc);
            cur = '{cyc, cyc, 8'h00};
          end else begin
            cur = pend.pop_front();
            chk("start_cycle", cyc, cur.start);
          end
          mon_active = 1'b1;
          mon_pos    = 0;
        end else begin
          chk("idle_busy", int'(tx_busy), 0);
          chk("idle_done", int'(tx_done), 0);
        end
      end
      if (mon_active) begin
        if (mon_pos < BaudDiv) expl = 0;
        else if (mon_pos < 9 * BaudDiv) expl = int'(cur.data[(mon_pos - BaudDiv) / BaudDiv]);
        else expl = 1;
        chk("uart_tx", int'(uart_tx), expl);
        chk("frame_busy", int'(tx_busy), 1);
        chk("tx_done", int'(tx_done), (mon_pos == FrameLen - 1) ? 1 : 0);
        mon_pos++;
        if (mon_pos == FrameLen) mon_active = 1'b0;
      end
    end
  end

  // Offer a byte from a falling edge and hold it until accepted.
  task automatic send(input logic [7:0] b);
    int  t = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!done && t < 400) begin
      if (in_ready) begin
        add_entry(b);
        done = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout at cycle %0d: got no acceptance, expected in_ready", cyc);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((pend.size() != 0 || mon_active) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout at cycle %0d: got %0d pending, expected 0", cyc, pend.size());
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_uart_tx"}, int'(uart_tx), 1);
    chk({tag, "_tx_busy"}, int'(tx_busy), 0);
    chk({tag, "_tx_done"}, int'(tx_done), 0);
    chk({tag, "_fifo_count"}, int'(fifo_count), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int s_a5;
    int gap;
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single byte from idle.
    send(8'h55);
    wait_idle();

    // Burst of three consecutive writes.
    peak_cnt = 0;
    send(8'h41);
    send(8'h42);
    send(8'h43);
    wait_idle();
    chk("burst_peak", peak_cnt, 2);

    // Backpressure: eight bytes offered continuously.
    for (int i = 0; i < 8; i++) send(8'(i));
    wait_idle();

    // Full FIFO with a byte held against the STOP pop.
    peak_cnt = 0;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
    chk("full_peak", peak_cnt, Depth);
    wait_idle();

    // Reset during data bit 3 of 0xA5 with two bytes queued.
    send(8'hA5);
    s_a5 = last_start;
    send(8'h01);
    send(8'h02);
    while (cyc < s_a5 + 17) @(negedge clk);
    #2 rst_n = 1'b0;
    pend.delete();
    last_start = -1000000;
    #1 check_reset_values("midreset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    send(8'h3C);
    wait_idle();

    // Randomised traffic with random gaps.
    repeat (25) begin
      gap = int'($urandom_range(0, 60));
      repeat (gap) @(negedge clk);
      send(8'($urandom));
    end
    wait_idle();
    chk("pend_empty", pend.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
